// File: rtl/usb_bridge_arb_if.sv
// Handshake bundle between the source FIFOs, the arbiter and the USB TX path.
// No latency of its own; the arbiter is on the master modport and the environment on the slave modport.
// Backpressure: accept_i stalls the arbiter's output, and src_pop_o drains the source FIFOs.
interface usb_bridge_arb_if #(
    parameter int NUM_SRC = 2,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 1
);
    logic                     enable_i;
    logic [NUM_SRC*WIDTH-1:0] src_data_i;
    logic [NUM_SRC-1:0]       src_valid_i;
    logic [NUM_SRC-1:0]       src_pop_o;
    logic [WIDTH-1:0]         data_o;
    logic                     valid_o;
    logic [ID_W-1:0]          id_o;
    logic                     last_o;
    logic                     accept_i;
    logic                     busy_o;

    modport master (
        input  enable_i, src_data_i, src_valid_i, accept_i,
        output src_pop_o, data_o, valid_o, id_o, last_o, busy_o
    );

    modport slave (
        output enable_i, src_data_i, src_valid_i, accept_i,
        input  src_pop_o, data_o, valid_o, id_o, last_o, busy_o
    );
endinterface

// File: rtl/usb_bridge_arb.sv
// Round-robin arbiter that shares one USB TX byte path between NUM_SRC FIFOs, in bursts of up to MAX_BURST bytes.
// Latency: one cycle of arbitration in IDLE, then the granted FIFO's data passes straight through at one byte per cycle.
// Backpressure: when accept_i is low the offered byte and the grant are held, and FIFOs are popped only on accepted beats.
module usb_bridge_arb #(
    parameter int NUM_SRC   = 2,
    parameter int WIDTH     = 8,
    parameter int ID_W      = 1,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    usb_bridge_arb_if.master bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q;
    logic [ID_W-1:0]   grant_q;
    logic [ID_W-1:0]   last_grant_q;
    logic [CNT_W-1:0]  beat_q;

    logic [ID_W:0]     rr_sum;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_vld;
    logic              busy;
    logic              cur_vld;
    logic              xfer;
    logic              at_last;
    logic [NUM_SRC-1:0] pop;

    // Scan from the farthest offset down, so the nearest valid source after last_grant_q wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        rr_sum   = '0;
        for (int off = NUM_SRC; off >= 1; off--) begin
            rr_sum = {1'b0, last_grant_q} + (ID_W+1)'(off);
            if (rr_sum >= (ID_W+1)'(NUM_SRC)) begin
                rr_sum = rr_sum - (ID_W+1)'(NUM_SRC);
            end
            if (bus.src_valid_i[rr_sum[ID_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = rr_sum[ID_W-1:0];
            end
        end
    end

    assign busy    = (state_q == BUSY);
    assign cur_vld = busy & bus.src_valid_i[grant_q];
    assign xfer    = cur_vld & bus.accept_i;
    assign at_last = (beat_q == CNT_W'(MAX_BURST - 1));

    always_comb begin
        pop          = '0;
        pop[grant_q] = xfer;
    end

    assign bus.valid_o   = cur_vld;
    assign bus.data_o    = cur_vld ? bus.src_data_i[grant_q*WIDTH +: WIDTH] : '0;
    assign bus.id_o      = busy ? grant_q : '0;
    assign bus.last_o    = cur_vld & at_last;
    assign bus.busy_o    = busy;
    assign bus.src_pop_o = pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NUM_SRC - 1);
            beat_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.enable_i && pick_vld) begin
                        grant_q <= pick_idx;
                        beat_q  <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // A drained source and a last-beat transfer cannot both fire, because a last beat needs valid.
                    if (!cur_vld) begin
                        state_q      <= IDLE;
                        last_grant_q <= grant_q;
                    end else if (bus.accept_i) begin
                        if (at_last) begin
                            state_q      <= IDLE;
                            last_grant_q <= grant_q;
                            beat_q       <= '0;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
